// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one combinational 64-bit ALU among NUM_REQ (2..4) requesters.
// Latency: a request granted at edge N shows on rsp_* from edge N (one registered stage).
// Backpressure: while the response register is full and rsp_ready is low, req_ready is all zero and ptr is frozen.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      per-requester handshake (req_ready is one-hot or zero)
//   req_op/req_a/req_b       per-requester ALU select (4b) and operands (64b), packed by index
//   rsp_valid/rsp_ready      response handshake; rsp_id names the owning requester
//   rsp_result               registered ALU result
//   stat_grants              32-bit saturating grant counter per requester
//
// Build option: define ALU_ARB_STATS_EN to build the grant counters; otherwise
// stat_grants is tied to zero and arbitration is unchanged.

// Combinational 64-bit ALU. Select codes outside the table return 0.
module alu (
    input  logic [3:0]  alu_select,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] result
);
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    always_comb begin
        result = '0;
        case (alu_select)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << b[5:0];
            ALU_SLT:  result = {63'b0, $signed(a) < $signed(b)};
            ALU_SLTU: result = {63'b0, a < b};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> b[5:0];
            ALU_SRA:  result = $unsigned($signed(a) >>> b[5:0]);
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end
endmodule

module alu_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [4*NUM_REQ-1:0]    req_op,
    input  logic [64*NUM_REQ-1:0]   req_a,
    input  logic [64*NUM_REQ-1:0]   req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [1:0]              rsp_id,
    output logic [63:0]             rsp_result,
    output logic [32*NUM_REQ-1:0]   stat_grants
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  rsp_id_q, rsp_id_d;
    logic [63:0] result_q, result_d;

    logic        can_issue;
    logic        found;
    logic        grant_vld;
    logic [1:0]  gidx;
    logic [1:0]  mux_idx;
    logic [2:0]  probe;
    logic [3:0]  alu_sel;
    logic [63:0] alu_a, alu_b, alu_res;

    // The slot frees up in the same cycle the consumer drains it, so a FULL
    // register with rsp_ready can be overwritten without a bubble.
    assign can_issue = (state_q == EMPTY) || rsp_ready;

    // Round-robin search starting at ptr_q, wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        probe = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            probe = {1'b0, ptr_q} + 3'(k);
            if (probe >= 3'(NUM_REQ)) begin
                probe = probe - 3'(NUM_REQ);
            end
            if (!found && req_valid[probe[1:0]]) begin
                found = 1'b1;
                gidx  = probe[1:0];
            end
        end
    end

    assign grant_vld = found && can_issue && !rst;

    always_comb begin
        req_ready = '0;
        if (grant_vld) begin
            req_ready[gidx] = 1'b1;
        end
    end

    // Without a grant the ALU is fed from slice 0; its result is ignored then.
    assign mux_idx = grant_vld ? gidx : 2'd0;
    assign alu_sel = req_op[{mux_idx, 2'b00} +: 4];
    assign alu_a   = req_a[{mux_idx, 6'b000000} +: 64];
    assign alu_b   = req_b[{mux_idx, 6'b000000} +: 64];

    alu u_alu (
        .alu_select (alu_sel),
        .a          (alu_a),
        .b          (alu_b),
        .result     (alu_res)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        rsp_id_d = rsp_id_q;
        result_d = result_q;
        if (grant_vld) begin
            state_d  = FULL;
            result_d = alu_res;
            rsp_id_d = gidx;
            ptr_d    = (gidx == 2'(NUM_REQ - 1)) ? 2'd0 : gidx + 2'd1;
        end else if (state_q == FULL && rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            ptr_q    <= '0;
            rsp_id_q <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            rsp_id_q <= rsp_id_d;
            result_q <= result_d;
        end
    end

    assign rsp_valid  = (state_q == FULL);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = result_q;

`ifdef ALU_ARB_STATS_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stats
        logic [31:0] cnt_q, cnt_d;

        // Saturate rather than wrap so a long run never looks like few grants.
        always_comb begin
            cnt_d = cnt_q;
            if (grant_vld && gidx == 2'(i) && cnt_q != 32'hFFFF_FFFF) begin
                cnt_d = cnt_q + 32'd1;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign stat_grants[32*i +: 32] = cnt_q;
    end
`else
    assign stat_grants = '0;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of alu_arbiter grant order, results, backpressure, reset and stats.
// Inputs change just after a rising edge; req_ready is checked mid-cycle, rsp_* 1 time unit after the edge.
// Each comparison is an immediate assertion; the summary reports passes over total.
module tb_alu_arbiter;
    localparam int NUM_REQ = 4;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_SLL   = 4'd2;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_OR    = 4'd8;
    localparam logic [3:0] OP_AND   = 4'd9;
    localparam logic [3:0] OP_UNDEF = 4'hF;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [4*NUM_REQ-1:0]   req_op;
    logic [64*NUM_REQ-1:0]  req_a;
    logic [64*NUM_REQ-1:0]  req_b;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [1:0]             rsp_id;
    logic [63:0]            rsp_result;
    logic [32*NUM_REQ-1:0]  stat_grants;

    int n_pass  = 0;
    int n_total = 0;

    alu_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .stat_grants (stat_grants)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic set_req(input int i, input logic v, input logic [3:0] op,
                           input logic [63:0] a, input logic [63:0] b);
        req_valid[i]      = v;
        req_op[4*i +: 4]  = op;
        req_a[64*i +: 64] = a;
        req_b[64*i +: 64] = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        rsp_ready = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;

        // Reset state, with req0 already waiting.
        set_req(0, 1'b1, OP_ADD, 64'd5, 64'd7);
        tick();
        tick();
        chk("rst_valid",  64'(rsp_valid), 64'd0);
        chk("rst_id",     64'(rsp_id),    64'd0);
        chk("rst_result", rsp_result,     64'd0);
        chk("rst_ready",  64'(req_ready), 64'd0);

        // Single ADD: 5 + 7.
        rst = 1'b0;
        #1;
        chk("add_ready", 64'(req_ready), 64'h1);
        tick();
        set_req(0, 1'b0, OP_ADD, 64'd0, 64'd0);
        chk("add_valid",  64'(rsp_valid), 64'd1);
        chk("add_id",     64'(rsp_id),    64'd0);
        chk("add_result", rsp_result,     64'd12);

        // Drain with nothing pending empties the register (ptr now 1).
        tick();
        chk("drain_valid", 64'(rsp_valid), 64'd0);

        // Undefined select on req2 yields 0 (ptr -> 3).
        set_req(2, 1'b1, OP_UNDEF, 64'd123, 64'd456);
        #1;
        chk("undef_ready", 64'(req_ready), 64'h4);
        tick();
        set_req(2, 1'b0, OP_ADD, 64'd0, 64'd0);
        chk("undef_id",     64'(rsp_id), 64'd2);
        chk("undef_result", rsp_result,  64'd0);

        // Fairness after req2: req3 before req1.
        set_req(1, 1'b1, OP_ADD, 64'd1, 64'd1);
        set_req(3, 1'b1, OP_OR, 64'h10, 64'h01);
        #1;
        chk("fair_ready3", 64'(req_ready), 64'h8);
        tick();
        set_req(3, 1'b0, OP_ADD, 64'd0, 64'd0);
        chk("fair_id3",     64'(rsp_id), 64'd3);
        chk("fair_result3", rsp_result,  64'h11);
        #1;
        chk("fair_ready1", 64'(req_ready), 64'h2);
        tick();
        set_req(1, 1'b0, OP_ADD, 64'd0, 64'd0);
        chk("fair_id1",     64'(rsp_id), 64'd1);
        chk("fair_result1", rsp_result,  64'd2);

        // Backpressure: buffer XOR 0xFF ^ 0x0F (ptr 2 -> search finds req0).
        set_req(0, 1'b1, OP_XOR, 64'hFF, 64'h0F);
        #1;
        chk("bp_load_ready", 64'(req_ready), 64'h1);
        tick();
        set_req(0, 1'b0, OP_ADD, 64'd0, 64'd0);
        chk("bp_load_result", rsp_result, 64'hF0);
        rsp_ready = 1'b0;
        set_req(1, 1'b1, OP_ADD, 64'd3, 64'd4);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_ready", 64'(req_ready), 64'd0);
            tick();
            chk("bp_hold_result", rsp_result,     64'hF0);
            chk("bp_hold_valid",  64'(rsp_valid), 64'd1);
        end
        // Release: ptr stayed at 1, so req1 goes in the same cycle.
        rsp_ready = 1'b1;
        #1;
        chk("bp_rel_ready", 64'(req_ready), 64'h2);
        tick();
        set_req(1, 1'b0, OP_ADD, 64'd0, 64'd0);
        chk("bp_rel_valid",  64'(rsp_valid), 64'd1);
        chk("bp_rel_id",     64'(rsp_id),    64'd1);
        chk("bp_rel_result", rsp_result,     64'd7);

        // Reset while FULL and stalled; req1/req3 stay pending.
        rsp_ready = 1'b0;
        set_req(1, 1'b1, OP_SLL, 64'd1, 64'd4);
        set_req(3, 1'b1, OP_AND, 64'hF0F0, 64'hFF00);
        #1;
        chk("mid_stall_ready", 64'(req_ready), 64'd0);
        rst = 1'b1;
        rsp_ready = 1'b1;
        #1;
        chk("mid_rst_ready", 64'(req_ready), 64'd0);
        tick();
        chk("mid_rst_valid",  64'(rsp_valid), 64'd0);
        chk("mid_rst_result", rsp_result,     64'd0);
        chk("mid_rst_id",     64'(rsp_id),    64'd0);
        rst = 1'b0;
        #1;
        chk("mid_ready1", 64'(req_ready), 64'h2);
        tick();
        set_req(1, 1'b0, OP_ADD, 64'd0, 64'd0);
        chk("mid_id1",     64'(rsp_id), 64'd1);
        chk("mid_result1", rsp_result,  64'd16);
        #1;
        chk("mid_ready3", 64'(req_ready), 64'h8);
        tick();
        set_req(3, 1'b0, OP_ADD, 64'd0, 64'd0);
        chk("mid_id3",     64'(rsp_id), 64'd3);
        chk("mid_result3", rsp_result,  64'hF000);

        // Full contention from ptr 0: SUB 100 - id, grants 0,1,2,3,0.
        for (int i = 0; i < NUM_REQ; i++) begin
            set_req(i, 1'b1, OP_SUB, 64'd100, 64'(i));
        end
        for (int c = 0; c < 5; c++) begin
            int exp_id;
            exp_id = c % NUM_REQ;
            #1;
            chk("cont_ready", 64'(req_ready), 64'(1 << exp_id));
            tick();
            chk("cont_valid",  64'(rsp_valid), 64'd1);
            chk("cont_id",     64'(rsp_id),    64'(exp_id));
            chk("cont_result", rsp_result,     64'(100 - exp_id));
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            set_req(i, 1'b0, OP_ADD, 64'd0, 64'd0);
        end

        // Third grant to req1 since reset (ptr is 1).
        set_req(1, 1'b1, OP_ADD, 64'd0, 64'd0);
        tick();
        set_req(1, 1'b0, OP_ADD, 64'd0, 64'd0);
        chk("stat_grant_id", 64'(rsp_id), 64'd1);
`ifdef ALU_ARB_STATS_EN
        chk("stat_req1", 64'(stat_grants[63:32]), 64'd3);
        chk("stat_req0", 64'(stat_grants[31:0]),  64'd2);
        force dut.g_stats[1].cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.g_stats[1].cnt_q;
        set_req(1, 1'b1, OP_ADD, 64'd0, 64'd0);
        tick();
        set_req(1, 1'b0, OP_ADD, 64'd0, 64'd0);
        chk("stat_sat", 64'(stat_grants[63:32]), 64'hFFFF_FFFF);
`else
        chk("stat_off_lo", stat_grants[63:0],   64'd0);
        chk("stat_off_hi", stat_grants[127:64], 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
